locker_bank: RTL

Parametrised multi-box takeaway locker controller. It holds NBOX boxes, each with a stored KEYW-bit pickup code. Deposits go to the lowest free box. Collections are checked against the stored code, and a box locks out after MAXTRY consecutive wrong codes until a supervisor unlock. It sits between the front-panel input decoder (request strobe, function, box select, keypad) and the status LED/display driver.

---
 rtl/locker_bank_if.sv | 36 +++
 rtl/locker_bank.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/locker_bank_if.sv
// Front-panel / display-side bundle for locker_bank.
// Handshake: req/unlock/ack are sampled at a rising edge only while the controller is able to take them
// (busy=0 for req/unlock, state ERR for ack); done is a one-cycle result pulse, err holds until ack.
interface locker_bank_if #(
    parameter int NBOX = 4,
    parameter int KEYW = 4
);
    localparam int IDXW = $clog2(NBOX);

    logic            req;
    logic [1:0]      func;
    logic [IDXW-1:0] box_sel;
    logic [KEYW-1:0] key;
    logic            unlock;
    logic            ack;
    logic            busy;
    logic            done;
    logic [IDXW-1:0] box_idx;
    logic [NBOX-1:0] occ;
    logic [NBOX-1:0] locked;
    logic [IDXW:0]   count;
    logic            full;
    logic            empty;
    logic [2:0]      err;
    logic [1:0]      dbg_state;

    modport master (
        output req, func, box_sel, key, unlock, ack,
        input  busy, done, box_idx, occ, locked, count, full, empty, err, dbg_state
    );

    modport slave (
        input  req, func, box_sel, key, unlock, ack,
        output busy, done, box_idx, occ, locked, count, full, empty, err, dbg_state
    );
endinterface

// File: rtl/locker_bank.sv
// Multi-box takeaway locker: deposits fill the lowest free box, collections check the stored
// pickup code, and repeated wrong codes lock a box until a supervisor unlock.
module locker_bank #(
    parameter int NBOX   = 4,
    parameter int KEYW   = 4,
    parameter int MAXTRY = 3
) (
    input logic          clk,
    input logic          reset_n,
    locker_bank_if.slave bus
);
    localparam int IDXW = $clog2(NBOX);
    localparam int FW   = $clog2(MAXTRY + 1);

    typedef enum logic [1:0] {IDLE, ALLOC, CHECK, ERR} state_t;

    state_t          state, state_d;
    logic [NBOX-1:0] occ, locked;
    logic [KEYW-1:0] code [NBOX];
    logic [FW-1:0]   fail [NBOX];
    logic [KEYW-1:0] key_q;
    logic [IDXW-1:0] box_q, box_idx, free_idx;
    logic [2:0]      err;
    logic            done;
    logic [IDXW:0]   count_w;
    logic            full_w, match;
    logic [FW-1:0]   fail_inc;

    always_comb begin
        count_w = '0;
        for (int i = 0; i < NBOX; i++) count_w = count_w + (IDXW+1)'(occ[i]);
    end

    assign full_w   = (count_w == (IDXW+1)'(NBOX));
    assign match    = (code[box_q] == key_q);
    assign fail_inc = fail[box_q] + 1'b1;

    // Descending scan so the lowest free index wins.
    always_comb begin
        free_idx = '0;
        for (int i = NBOX - 1; i >= 0; i--) begin
            if (!occ[i]) free_idx = IDXW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!bus.unlock && bus.req) begin
                    if (bus.func == 2'b01)
                        state_d = full_w ? ERR : ALLOC;
                    else if (bus.func == 2'b10)
                        state_d = (locked[bus.box_sel] || !occ[bus.box_sel]) ? ERR : CHECK;
                end
            end
            ALLOC:   state_d = IDLE;
            CHECK:   state_d = match ? IDLE : ERR;
            ERR:     if (bus.ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ     <= '0;
            locked  <= '0;
            key_q   <= '0;
            box_q   <= '0;
            box_idx <= '0;
            err     <= '0;
            done    <= 1'b0;
            for (int i = 0; i < NBOX; i++) begin
                code[i] <= '0;
                fail[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Unlock wins over a coincident request, which is simply dropped.
                    if (bus.unlock) begin
                        occ[bus.box_sel]    <= 1'b0;
                        locked[bus.box_sel] <= 1'b0;
                        fail[bus.box_sel]   <= '0;
                        code[bus.box_sel]   <= '0;
                    end else if (bus.req && bus.func == 2'b01) begin
                        if (full_w) err <= 3'd1;
                        else        key_q <= bus.key;
                    end else if (bus.req && bus.func == 2'b10) begin
                        if (locked[bus.box_sel])    err <= 3'd4;
                        else if (!occ[bus.box_sel]) err <= 3'd2;
                        else begin
                            box_q <= bus.box_sel;
                            key_q <= bus.key;
                        end
                    end
                end
                ALLOC: begin
                    code[free_idx] <= key_q;
                    occ[free_idx]  <= 1'b1;
                    fail[free_idx] <= '0;
                    box_idx        <= free_idx;
                    done           <= 1'b1;
                end
                CHECK: begin
                    if (match) begin
                        occ[box_q]  <= 1'b0;
                        fail[box_q] <= '0;
                        box_idx     <= box_q;
                        done        <= 1'b1;
                    end else begin
                        // A locked box never reaches CHECK, so the counter tops out at MAXTRY.
                        fail[box_q] <= fail_inc;
                        if (fail_inc == FW'(MAXTRY)) locked[box_q] <= 1'b1;
                        err <= 3'd3;
                    end
                end
                ERR: if (bus.ack) err <= '0;
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.box_idx   = box_idx;
    assign bus.occ       = occ;
    assign bus.locked    = locked;
    assign bus.count     = count_w;
    assign bus.full      = full_w;
    assign bus.empty     = (count_w == '0);
    assign bus.err       = err;
    assign bus.dbg_state = state;
endmodule
